// File: rtl/led_bcd_source_pkg.sv
// Shared constants and state encoding for the seven-segment BCD source path.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package led_pkg;

  typedef enum logic [1:0] {
    LED_IDLE   = 2'd0,
    LED_SHIFT  = 2'd1,
    LED_FINISH = 2'd2
  } led_state_e;

  localparam int          LED_WIDTH      = 32;
  localparam int          LED_DIGITS     = 8;
  localparam int          LED_BCD_DIGITS = 10;
  localparam int          LED_ITER_LAST  = LED_WIDTH - 1;
  localparam logic [31:0] LED_SAT        = 32'h9999_9999;
  localparam int unsigned LED_DEC_MAX    = 99_999_999;

endpackage

// File: rtl/led_bcd_source_if.sv
// Request/response bundle between the CPU-side value source and led_bcd_source.
// Latency: n/a (wiring only).
// Backpressure: start is dropped while busy is high; the master must watch busy/done.
//   master: drives start, dec_mode, bin_in; observes busy, done, overflow, leddata.
//   slave : the converter; mirror image of master.
interface led_bcd_source_if;
  import led_pkg::*;

  logic                      start;
  logic                      dec_mode;
  logic [LED_WIDTH-1:0]      bin_in;
  logic                      busy;
  logic                      done;
  logic                      overflow;
  logic [4*LED_DIGITS-1:0]   leddata;

  modport master (
    output start, dec_mode, bin_in,
    input  busy, done, overflow, leddata
  );

  modport slave (
    input  start, dec_mode, bin_in,
    output busy, done, overflow, leddata
  );

endinterface

// File: rtl/led_bcd_source_digit_adj.sv
// Double-dabble correction cell: adds 3 to a BCD digit that is 5 or more.
// Latency: combinational.
// Backpressure: none.
//   digit_i: current 4-bit BCD digit; digit_o: corrected digit, ready for the left shift.
module bcd_digit_adj (
  input  logic [3:0] digit_i,
  output logic [3:0] digit_o
);

  assign digit_o = (digit_i >= 4'd5) ? (digit_i + 4'd3) : digit_i;

endmodule

// File: rtl/led_bcd_source.sv
// Binary-to-display-word source: hex pass-through or iterative double-dabble to 8 BCD digits with saturation.
// Latency: hex 1 cycle after accepted start; decimal 33 cycles (32 shift iterations + 1 finish).
// Backpressure: start is only accepted in IDLE; while busy it is dropped, not queued.
//   clk, rst_n : single clock, synchronous active-low reset.
//   bus (slave): start/dec_mode/bin_in in; busy/done/overflow/leddata out, all registered.
module led_bcd_source
  import led_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int DIGITS = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  led_bcd_source_if.slave    bus
);

  localparam int BCD_W = 4 * LED_BCD_DIGITS;

  led_state_e                state_q, state_d;
  logic [4:0]                cnt_q, cnt_d;
  logic [WIDTH-1:0]          shift_q, shift_d;
  logic [BCD_W-1:0]          bcd_q, bcd_d;
  logic [BCD_W-1:0]          bcd_adj;
  logic [4*DIGITS-1:0]       leddata_q, leddata_d;
  logic                      overflow_q, overflow_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;

  // A 32-bit value never pushes the top BCD digit to 5 or more, so the
  // corrected MSB is always shifted out as zero.
  logic                      adj_msb_unused;
  assign adj_msb_unused = bcd_adj[BCD_W-1];

  for (genvar g = 0; g < LED_BCD_DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit_i (bcd_q[4*g +: 4]),
      .digit_o (bcd_adj[4*g +: 4])
    );
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    bcd_d      = bcd_q;
    leddata_d  = leddata_q;
    overflow_d = overflow_q;
    busy_d     = busy_q;
    done_d     = 1'b0;

    case (state_q)
      LED_IDLE: begin
        if (bus.start) begin
          if (bus.dec_mode) begin
            shift_d = bus.bin_in;
            bcd_d   = '0;
            cnt_d   = '0;
            busy_d  = 1'b1;
            state_d = LED_SHIFT;
          end else begin
            leddata_d  = bus.bin_in;
            overflow_d = 1'b0;
            done_d     = 1'b1;
          end
        end
      end

      LED_SHIFT: begin
        // Correct every digit first, then shift {bcd, shift} left as one word.
        {bcd_d, shift_d} = {bcd_adj[BCD_W-2:0], shift_q, 1'b0};
        cnt_d            = cnt_q + 5'd1;
        if (cnt_q == 5'(LED_ITER_LAST)) begin
          state_d = LED_FINISH;
        end
      end

      LED_FINISH: begin
        // Anything in the two digits above the display means > 99_999_999.
        if (bcd_q[BCD_W-1:4*LED_DIGITS] != '0) begin
          leddata_d  = LED_SAT;
          overflow_d = 1'b1;
        end else begin
          leddata_d  = bcd_q[4*LED_DIGITS-1:0];
          overflow_d = 1'b0;
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = LED_IDLE;
      end

      default: begin
        busy_d  = 1'b0;
        state_d = LED_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= LED_IDLE;
      cnt_q      <= '0;
      shift_q    <= '0;
      bcd_q      <= '0;
      leddata_q  <= '0;
      overflow_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      bcd_q      <= bcd_d;
      leddata_q  <= leddata_d;
      overflow_q <= overflow_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.overflow = overflow_q;
  assign bus.leddata  = leddata_q;

endmodule

// File: tb/tb_led_bcd_source.sv
// Self-checking bench for led_bcd_source: directed corner values, abort-by-reset, then random mix.
// Latency: expects 1 cycle (hex) and 33 cycles (decimal) from the accepting edge.
// Backpressure: checks that a start issued while busy is dropped.
module tb_led_bcd_source;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  led_bcd_source_if bus ();

  led_bcd_source dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_led = '0;
  logic        exp_ovf = 1'b0;

  // Reference: decimal digits by plain division, saturating above eight digits.
  function automatic logic [31:0] ref_dec_word(input int unsigned v);
    logic [31:0] w;
    int unsigned r;
    w = '0;
    r = v;
    if (v > 32'd99_999_999) return 32'h9999_9999;
    for (int i = 0; i < 8; i++) begin
      w[4*i +: 4] = 4'(r % 10);
      r = r / 10;
    end
    return w;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_hex(input logic [31:0] v);
    @(negedge clk);
    bus.start = 1'b1; bus.dec_mode = 1'b0; bus.bin_in = v;
    @(negedge clk);
    bus.start = 1'b0; bus.bin_in = $urandom;
    exp_led = v;
    exp_ovf = 1'b0;
    check("hex_done",    32'(bus.done), 32'd1);
    check("hex_busy",    32'(bus.busy), 32'd0);
    check("hex_leddata", bus.leddata, exp_led);
    check("hex_ovf",     32'(bus.overflow), 32'(exp_ovf));
    @(negedge clk);
    check("hex_done_pulse", 32'(bus.done), 32'd0);
    check("hex_hold",       bus.leddata, exp_led);
  endtask

  task automatic do_dec(input logic [31:0] v);
    int lat;
    int busy_cnt;
    bit stable;
    @(negedge clk);
    bus.start = 1'b1; bus.dec_mode = 1'b1; bus.bin_in = v;
    @(negedge clk);
    // Inputs are scrambled after acceptance; the block must work from its copy.
    bus.start = 1'b0; bus.dec_mode = 1'($urandom); bus.bin_in = $urandom;
    check("dec_busy_accept", 32'(bus.busy), 32'd1);
    lat = 0; busy_cnt = 1; stable = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (bus.done) begin
        lat = i;
        break;
      end
      if (bus.busy) busy_cnt++;
      if (bus.leddata !== exp_led) stable = 1'b0;
    end
    exp_led = ref_dec_word(v);
    exp_ovf = (v > 32'd99_999_999);
    check("dec_latency",  32'(lat), 32'd33);
    check("dec_busy_cyc", 32'(busy_cnt), 32'd33);
    check("dec_stable",   32'(stable), 32'd1);
    check("dec_leddata",  bus.leddata, exp_led);
    check("dec_ovf",      32'(bus.overflow), 32'(exp_ovf));
    check("dec_busy_end", 32'(bus.busy), 32'd0);
    @(negedge clk);
    check("dec_done_pulse", 32'(bus.done), 32'd0);
  endtask

  initial begin
    bit          seen_done;
    logic [31:0] v;
    bus.start = 1'b0; bus.dec_mode = 1'b0; bus.bin_in = '0;

    repeat (2) @(negedge clk);
    check("rst_leddata", bus.leddata, 32'd0);
    check("rst_ovf",     32'(bus.overflow), 32'd0);
    check("rst_busy",    32'(bus.busy), 32'd0);
    check("rst_done",    32'(bus.done), 32'd0);
    rst_n = 1'b1;

    do_dec(32'h00BC_614E);
    do_dec(32'h05F5_E0FF);
    do_dec(32'h05F5_E100);
    do_dec(32'hFFFF_FFFF);
    do_dec(32'h0000_0000);
    do_hex(32'hDEAD_BEEF);

    // Abort scenario: start ignored mid-run, then reset mid-run.
    @(negedge clk);
    bus.start = 1'b1; bus.dec_mode = 1'b1; bus.bin_in = 32'd12345678;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    bus.start = 1'b1; bus.dec_mode = 1'b0; bus.bin_in = 32'd5;
    @(negedge clk);
    bus.start = 1'b0;
    check("ign_busy",    32'(bus.busy), 32'd1);
    check("ign_done",    32'(bus.done), 32'd0);
    check("ign_leddata", bus.leddata, exp_led);
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_led = '0;
    exp_ovf = 1'b0;
    check("abort_leddata", bus.leddata, 32'd0);
    check("abort_busy",    32'(bus.busy), 32'd0);
    check("abort_ovf",     32'(bus.overflow), 32'd0);
    seen_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done) seen_done = 1'b1;
    end
    check("abort_no_done", 32'(seen_done), 32'd0);
    do_dec(32'd42);

    for (int n = 0; n < 30; n++) begin
      case ($urandom % 3)
        0:       v = $urandom;
        1:       v = $urandom_range(0, 99_999_999);
        default: v = $urandom_range(99_999_990, 100_000_010);
      endcase
      if ($urandom % 2) do_dec(v);
      else              do_hex(v);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/led_bcd_source.md
# led_bcd_source

Upstream stage of the 8-digit seven-segment display path. The block takes a 32-bit binary value from the CPU side, such as a syscall print value or a cycle/instruction counter. It produces the 32-bit `leddata` word that the display driver splits into eight 4-bit digit codes, most significant nibble on the leftmost digit. In decimal mode it performs an iterative double-dabble binary-to-BCD conversion with saturation. In hex mode it passes the value through. The output is held stable between conversions so the display never shows intermediate values.

## Interface
- `WIDTH`, 32, binary input width. Fixed at 32.
- `DIGITS`, 8, display digits, giving `leddata` width 4*DIGITS. Fixed at 8.
- `clk` input 1: system clock, single clock domain.
- `rst_n` input 1: reset, synchronous, active-low.
- `start` input 1: request to load `bin_in`. Only sampled in IDLE.
- `dec_mode` input 1: 1 selects decimal (BCD) conversion, 0 selects hex pass-through. Sampled together with `start`.
- `bin_in` input 32: value to display. Sampled on the accepted `start` edge only.
- `busy` output 1: conversion in progress. `start` is ignored while `busy` is high.
- `done` output 1: one-cycle pulse when `leddata` has just been updated.
- `overflow` output 1: last decimal value exceeded 99_999_999. Held until the next update.
- `leddata` output 32: display word, held between updates.

## Operation
- Reset (`rst_n`=0 at a `clk` edge):
  - State goes to IDLE.
  - `leddata`=0, `overflow`=0, `busy`=0, `done`=0.
  - Shift and BCD registers are cleared.
- States are IDLE, SHIFT and FINISH.
- IDLE, with `start`=1 and `dec_mode`=0:
  - `leddata`<=`bin_in`, `overflow`<=0, `done`<=1.
  - State stays IDLE; `busy` stays 0.
- IDLE, with `start`=1 and `dec_mode`=1:
  - Shift register <= `bin_in`, 40-bit BCD register (10 digits) <= 0, iteration counter <= 0.
  - State goes to SHIFT; `busy`<=1.
- SHIFT, one iteration per cycle:
  - Every BCD digit >= 5 first gets +3.
  - Then {bcd, shift} is shifted left by 1 as a single concatenation.
  - The counter increments. After the 32nd iteration (counter was 31), the state goes to FINISH.
- FINISH, one cycle:
  - If the upper two BCD digits are nonzero: `leddata`<=32'h9999_9999, `overflow`<=1.
  - Otherwise: `leddata`<=low 8 BCD digits, `overflow`<=0.
  - `done`<=1, `busy`<=0, state goes to IDLE.
- `done` is 0 in every cycle other than those listed above.
- `start` while `busy` is high is dropped, not queued.
- `leddata` changes only on a `done` cycle or on reset.
- `bin_in` and `dec_mode` may change freely after acceptance; the block works from its internal copy.
- Reset mid-conversion aborts the conversion immediately. `leddata` returns to 0 and no `done` is produced.
- Wrap-around: the iteration counter is 5 bits and never wraps in normal operation. SHIFT exits at count 31.

## Timing
- Hex path: `start` accepted at edge k; `leddata` and `done`=1 are valid after edge k. Latency is 1 cycle.
- Decimal path: `start` accepted at edge k, so `busy`=1 after edge k.
  - Iterations run on edges k+1 … k+32.
  - FINISH runs on edge k+33, so `leddata`, `overflow` and `done`=1 are valid after edge k+33. Latency is 33 cycles.
- Back-to-back: a `start` presented in the `done` cycle is accepted, because the state is already IDLE.
- The display driver samples `leddata` continuously; a word change is atomic on one edge.
- All outputs are registered. No combinational path runs from inputs to outputs.

## Structure
- Shared package `led_pkg`:
  - state encoding `LED_IDLE`/`LED_SHIFT`/`LED_FINISH`
  - `LED_DIGITS`=8
  - `LED_BCD_DIGITS`=10
  - `LED_SAT`=32'h9999_9999
  - `LED_DEC_MAX`=99_999_999
- One sub-module, `bcd_digit_adj`: combinational 4-bit "add 3 if >= 5" cell, instantiated 10 times in a generate loop.
- FSM, counter, shift/BCD registers and output registers stay in `led_bcd_source`.

## Test plan
- Reset, then `dec_mode`=1, `bin_in`=32'h00BC_614E (12345678):
  - `busy` high 33 cycles.
  - `done` after edge k+33 with `leddata`=32'h1234_5678, `overflow`=0.
- Decimal 32'h05F5_E0FF (99_999_999) gives `leddata`=32'h9999_9999, `overflow`=0.
- Decimal 32'h05F5_E100 (100_000_000) gives `leddata`=32'h9999_9999, `overflow`=1.
- Decimal 32'hFFFF_FFFF also gives saturation with `overflow`=1.
- Decimal 0 gives `leddata`=0 after 33 cycles.
- Hex `bin_in`=32'hDEAD_BEEF:
  - `leddata`=32'hDEAD_BEEF and `done` one cycle after `start`; `busy` never asserted.
- Stimulus: start a decimal 12345678 conversion; pulse `start` with 32'd5 at iteration 10; pulse `rst_n` low at iteration 20.
  - The second start is ignored.
  - After reset, `leddata`=0, `busy`=0 and no `done` appears.
  - A following decimal 42 gives 32'h0000_0042.
